vram_rect_fill: RTL

//  Rectangle-fill engine on the write port of the 320x200x8 (RGB332) video RAM

---
 rtl/vram_rect_fill.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: a CPU-programmed 8-register window drives one VRAM pixel write per clock.
// Build option: define RECT_CLIP_EN to clip the rectangle against the screen edges.
module vram_rect_fill #(
    parameter int unsigned SCREEN_W  = 320,
    parameter int unsigned SCREEN_H  = 200,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_we,
    output logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] vram_address,
    output logic [7:0]  vram_wdata,
    output logic        vram_we
);

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    localparam logic [2:0] REG_X_LO  = 3'd0;
    localparam logic [2:0] REG_X_HI  = 3'd1;
    localparam logic [2:0] REG_Y     = 3'd2;
    localparam logic [2:0] REG_W_LO  = 3'd3;
    localparam logic [2:0] REG_W_HI  = 3'd4;
    localparam logic [2:0] REG_H     = 3'd5;
    localparam logic [2:0] REG_COLOR = 3'd6;
    localparam logic [2:0] REG_CTRL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    // CPU-visible registers
    logic [XW-1:0] x_reg, x_reg_n;
    logic [YW-1:0] y_reg, y_reg_n;
    logic [XW-1:0] w_reg, w_reg_n;
    logic [YW-1:0] h_reg, h_reg_n;
    logic [DW-1:0] color_reg, color_reg_n;
    logic          done_sticky, done_sticky_n;

    // Geometry captured at START, used for the whole fill
    logic [XW-1:0] x_lat, x_lat_n;
    logic [YW-1:0] y_lat, y_lat_n;
    logic [XW-1:0] w_lat, w_lat_n;
    logic [YW-1:0] h_lat, h_lat_n;
    logic [DW-1:0] color_lat, color_lat_n;

    // Walk state
    logic [XW-1:0] w_eff, w_eff_n;
    logic [YW-1:0] h_eff, h_eff_n;
    logic [XW-1:0] col, col_n;
    logic [YW-1:0] row, row_n;
    logic [AW-1:0] row_base, row_base_n;

    logic [DW-1:0] reg_rdata_n;
    logic          busy_n;
    logic          done_n;
    logic [AW-1:0] vram_address_n;
    logic [DW-1:0] vram_wdata_n;
    logic          vram_we_n;

    logic          ctrl_wr;
    logic          start_req;
    logic          abort_req;
    logic          col_last;
    logic          row_last;
    logic [XW-1:0] w_clip;
    logic [YW-1:0] h_clip;
    logic [AW-1:0] row_base_c;

    assign ctrl_wr   = reg_we && (reg_addr == REG_CTRL);
    assign start_req = ctrl_wr && reg_wdata[0];
    assign abort_req = ctrl_wr && reg_wdata[1];
    assign col_last  = (col == w_eff - XW'(1));
    assign row_last  = (row == h_eff - YW'(1));

    // First-pixel address; wraps modulo 2^16 by truncation
    assign row_base_c = AW'(32'(BASE_ADDR) + 32'(y_lat) * SCREEN_W + 32'(x_lat));

    // Effective rectangle size
    always_comb begin
        w_clip = w_lat;
        h_clip = h_lat;
`ifdef RECT_CLIP_EN
        if ((32'(x_lat) >= SCREEN_W) || (32'(y_lat) >= SCREEN_H)) begin
            w_clip = '0;
            h_clip = '0;
        end else begin
            if (32'(w_lat) > (SCREEN_W - 32'(x_lat))) begin
                w_clip = XW'(SCREEN_W - 32'(x_lat));
            end
            if (32'(h_lat) > (SCREEN_H - 32'(y_lat))) begin
                h_clip = YW'(SCREEN_H - 32'(y_lat));
            end
        end
`endif
    end

    // Next-state and walk logic
    always_comb begin
        state_n     = state;
        x_lat_n     = x_lat;
        y_lat_n     = y_lat;
        w_lat_n     = w_lat;
        h_lat_n     = h_lat;
        color_lat_n = color_lat;
        w_eff_n     = w_eff;
        h_eff_n     = h_eff;
        col_n       = col;
        row_n       = row;
        row_base_n  = row_base;

        case (state)
            IDLE: begin
                if (start_req) begin
                    x_lat_n     = x_reg;
                    y_lat_n     = y_reg;
                    w_lat_n     = w_reg;
                    h_lat_n     = h_reg;
                    color_lat_n = color_reg;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                row_base_n = row_base_c;
                col_n      = '0;
                row_n      = '0;
                w_eff_n    = w_clip;
                h_eff_n    = h_clip;
                if ((w_clip == '0) || (h_clip == '0)) begin
                    state_n = DONE;
                end else begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (col_last) begin
                    col_n      = '0;
                    row_n      = row + YW'(1);
                    row_base_n = row_base + AW'(SCREEN_W);
                    if (row_last) begin
                        state_n = DONE;
                    end
                end else begin
                    col_n = col + XW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // ABORT overrides everything, including a simultaneous START
        if (abort_req) begin
            state_n = IDLE;
        end
    end

    // Register file writes, sticky done and read mux
    always_comb begin
        x_reg_n       = x_reg;
        y_reg_n       = y_reg;
        w_reg_n       = w_reg;
        h_reg_n       = h_reg;
        color_reg_n   = color_reg;
        done_sticky_n = done_sticky;
        reg_rdata_n   = '0;

        if (reg_we && !busy) begin
            case (reg_addr)
                REG_X_LO:  x_reg_n[7:0] = reg_wdata;
                REG_X_HI:  x_reg_n[8]   = reg_wdata[0];
                REG_Y:     y_reg_n      = reg_wdata;
                REG_W_LO:  w_reg_n[7:0] = reg_wdata;
                REG_W_HI:  w_reg_n[8]   = reg_wdata[0];
                REG_H:     h_reg_n      = reg_wdata;
                REG_COLOR: color_reg_n  = reg_wdata;
                default:   ;
            endcase
        end

        if (ctrl_wr) begin
            done_sticky_n = 1'b0;
        end
        if (done_n) begin
            done_sticky_n = 1'b1;
        end

        case (reg_addr)
            REG_X_LO:  reg_rdata_n = x_reg[7:0];
            REG_X_HI:  reg_rdata_n = {7'b0, x_reg[8]};
            REG_Y:     reg_rdata_n = y_reg;
            REG_W_LO:  reg_rdata_n = w_reg[7:0];
            REG_W_HI:  reg_rdata_n = {7'b0, w_reg[8]};
            REG_H:     reg_rdata_n = h_reg;
            REG_COLOR: reg_rdata_n = color_reg;
            default:   reg_rdata_n = {6'b0, done_sticky, busy};
        endcase
    end

    // Outputs are registered copies of what the next state will drive
    always_comb begin
        busy_n         = (state_n == SETUP) || (state_n == FILL);
        done_n         = (state_n == DONE);
        vram_we_n      = (state_n == FILL);
        vram_address_n = vram_address;
        vram_wdata_n   = vram_wdata;
        if (vram_we_n) begin
            vram_address_n = row_base_n + AW'(col_n);
            vram_wdata_n   = color_lat_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            color_reg    <= '0;
            done_sticky  <= 1'b0;
            x_lat        <= '0;
            y_lat        <= '0;
            w_lat        <= '0;
            h_lat        <= '0;
            color_lat    <= '0;
            w_eff        <= '0;
            h_eff        <= '0;
            col          <= '0;
            row          <= '0;
            row_base     <= '0;
            reg_rdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            vram_address <= '0;
            vram_wdata   <= '0;
            vram_we      <= 1'b0;
        end else begin
            x_reg        <= x_reg_n;
            y_reg        <= y_reg_n;
            w_reg        <= w_reg_n;
            h_reg        <= h_reg_n;
            color_reg    <= color_reg_n;
            done_sticky  <= done_sticky_n;
            x_lat        <= x_lat_n;
            y_lat        <= y_lat_n;
            w_lat        <= w_lat_n;
            h_lat        <= h_lat_n;
            color_lat    <= color_lat_n;
            w_eff        <= w_eff_n;
            h_eff        <= h_eff_n;
            col          <= col_n;
            row          <= row_n;
            row_base     <= row_base_n;
            reg_rdata    <= reg_rdata_n;
            busy         <= busy_n;
            done         <= done_n;
            vram_address <= vram_address_n;
            vram_wdata   <= vram_wdata_n;
            vram_we      <= vram_we_n;
        end
    end

endmodule
